// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing: pixel/line counters with registered blanking, sync,
// data-enable and line/frame start markers, all aligned to the counts they describe.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_STOP  = HS_START + H_SYNC;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_STOP  = VS_START + V_SYNC;

  // Boundaries carried one bit wider than the counters so HS_STOP == H_TOTAL still fits.
  localparam int unsigned CW = CNT_W + 1;
  localparam logic [CNT_W:0] H_ACT_X  = CW'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_STA_X = CW'(HS_START);
  localparam logic [CNT_W:0] HS_STO_X = CW'(HS_STOP);
  localparam logic [CNT_W:0] V_ACT_X  = CW'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_STA_X = CW'(VS_START);
  localparam logic [CNT_W:0] VS_STO_X = CW'(VS_STOP);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if (64'(H_TOTAL) > (64'd1 << CNT_W)) begin : g_h_too_wide
    $error("H_TOTAL-1 does not fit in CNT_W bits");
  end
  if (64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_v_too_wide
    $error("V_TOTAL-1 does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] h_d, v_d;
  logic [CNT_W:0]   hx, vx;
  logic             hblnk_d, vblnk_d, hsync_d, vsync_d, de_d;
  logic             line_start_d, frame_start_d;

  always_comb begin
    h_d           = hcount;
    v_d           = vcount;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (restart) begin
      h_d           = '0;
      v_d           = '0;
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (en) begin
      if (hcount == H_LAST) begin
        h_d           = '0;
        v_d           = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
        line_start_d  = 1'b1;
        frame_start_d = (vcount == V_LAST);
      end else begin
        h_d = hcount + CNT_W'(1);
      end
    end
  end

  // Flags decode the next-state counts so they land in the same cycle as those counts.
  always_comb begin
    hx      = {1'b0, h_d};
    vx      = {1'b0, v_d};
    hblnk_d = (hx >= H_ACT_X);
    vblnk_d = (vx >= V_ACT_X);
    hsync_d = ((hx >= HS_STA_X) && (hx < HS_STO_X)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vx >= VS_STA_X) && (vx < VS_STO_X)) ? VSYNC_POL : ~VSYNC_POL;
    de_d    = ~hblnk_d & ~vblnk_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_d;
      vcount      <= v_d;
      hblnk       <= hblnk_d;
      vblnk       <= vblnk_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven by shared random stimulus and
// checked every cycle against a frame-position model, plus hand-computed pins.
module tb_vga_timing_gen;

  // Instance 0: small timing, instance 1: zero porches and inverted polarity, 2: defaults.
  localparam int HA[3] = '{16, 8, 800};
  localparam int HF[3] = '{4, 0, 40};
  localparam int HS[3] = '{6, 3, 128};
  localparam int HB[3] = '{5, 0, 88};
  localparam int VA[3] = '{10, 4, 600};
  localparam int VF[3] = '{2, 0, 1};
  localparam int VS[3] = '{3, 2, 4};
  localparam int VB[3] = '{2, 0, 23};
  localparam int HP[3] = '{1, 0, 1};
  localparam int VP[3] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic restart = 1'b0;

  logic [4:0]  hc0, vc0;
  logic [3:0]  hc1, vc1;
  logic [10:0] hc2, vc2;
  logic hb0, vb0, hs0, vs0, de0, ls0, fs0;
  logic hb1, vb1, hs1, vs1, de1, ls1, fs1;
  logic hb2, vb2, hs2, vs2, de2, ls2, fs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(5)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .hcount(hc0), .vcount(vc0),
    .hblnk(hb0), .vblnk(vb0), .hsync(hs0), .vsync(vs0), .de(de0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(0),
    .V_ACTIVE(4), .V_FP(0), .V_SYNC(2), .V_BP(0),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .hcount(hc1), .vcount(vc1),
    .hblnk(hb1), .vblnk(vb1), .hsync(hs1), .vsync(vs1), .de(de1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen u_dut2 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .hcount(hc2), .vcount(vc2),
    .hblnk(hb2), .vblnk(vb2), .hsync(hs2), .vsync(vs2), .de(de2),
    .line_start(ls2), .frame_start(fs2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each configuration is a single position within the frame.
  int pos[3];
  bit m_hb[3], m_vb[3], m_hs[3], m_vs[3], m_de[3], m_ls[3], m_fs[3];

  function automatic int ht(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vt(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  task automatic model_reset(input int i);
    pos[i]  = 0;
    m_hb[i] = 1'b0;
    m_vb[i] = 1'b0;
    m_de[i] = 1'b1;
    m_hs[i] = (HP[i] == 0);
    m_vs[i] = (VP[i] == 0);
    m_ls[i] = 1'b0;
    m_fs[i] = 1'b0;
  endtask

  task automatic model_flags(input int i);
    int h, v;
    bit in_hs, in_vs;
    h = pos[i] % ht(i);
    v = pos[i] / ht(i);
    in_hs = (h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]);
    in_vs = (v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]);
    m_hb[i] = (h >= HA[i]);
    m_vb[i] = (v >= VA[i]);
    m_de[i] = !m_hb[i] && !m_vb[i];
    m_hs[i] = (in_hs == (HP[i] != 0));
    m_vs[i] = (in_vs == (VP[i] != 0));
  endtask

  task automatic model_step(input int i, input bit r, input bit e);
    if (r) begin
      pos[i]  = 0;
      m_ls[i] = 1'b1;
      m_fs[i] = 1'b1;
      model_flags(i);
    end else if (e) begin
      pos[i]  = (pos[i] + 1) % (ht(i) * vt(i));
      m_ls[i] = (pos[i] % ht(i) == 0);
      m_fs[i] = (pos[i] == 0);
      model_flags(i);
    end else begin
      m_ls[i] = 1'b0;
      m_fs[i] = 1'b0;
    end
  endtask

  logic smp_rst = 1'b1;
  logic smp_en = 1'b0;
  logic smp_rs = 1'b0;

  always @(posedge clk) begin
    smp_rst <= rst;
    smp_en  <= en;
    smp_rs  <= restart;
  end

  // Compare process: advance the model for the edge just passed, then check all outputs.
  initial begin
    int a_h[3], a_v[3];
    bit [6:0] a_f[3];
    for (int i = 0; i < 3; i++) model_reset(i);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst || smp_rst) model_reset(i);
        else model_step(i, smp_rs, smp_en);
      end
      a_h[0] = int'(hc0); a_v[0] = int'(vc0);
      a_h[1] = int'(hc1); a_v[1] = int'(vc1);
      a_h[2] = int'(hc2); a_v[2] = int'(vc2);
      a_f[0] = {hb0, vb0, hs0, vs0, de0, ls0, fs0};
      a_f[1] = {hb1, vb1, hs1, vs1, de1, ls1, fs1};
      a_f[2] = {hb2, vb2, hs2, vs2, de2, ls2, fs2};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d hcount", i), a_h[i], pos[i] % ht(i));
        chk($sformatf("u%0d vcount", i), a_v[i], pos[i] / ht(i));
        chk($sformatf("u%0d flags{hb,vb,hs,vs,de,ls,fs}", i), int'(a_f[i]),
            int'({m_hb[i], m_vb[i], m_hs[i], m_vs[i], m_de[i], m_ls[i], m_fs[i]}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nls, nfs;
    nls = 0;
    nfs = 0;
    repeat (3) tick();
    chk("reset hcount", int'(hc0), 0);
    chk("reset de", int'(de0), 1);
    chk("reset hsync pol1", int'(hs0), 0);
    chk("reset hsync pol0", int'(hs1), 1);
    chk("reset vsync pol0", int'(vs1), 1);
    chk("reset hblnk", int'(hb2), 0);
    rst = 1'b0;
    tick();
    chk("idle after reset hcount", int'(hc0), 0);
    chk("idle after reset frame_start", int'(fs0), 0);
    en = 1'b1;
    for (int k = 1; k <= 1055; k++) begin
      tick();
      if (k <= 527) begin
        nls += int'(ls0);
        nfs += int'(fs0);
      end
      if (k == 1) begin
        chk("first step hcount", int'(hc0), 1);
        chk("first step vcount", int'(vc0), 0);
        chk("first step line_start", int'(ls0), 0);
      end
      if (k == 31) begin
        chk("small wrap hcount", int'(hc0), 0);
        chk("small wrap vcount", int'(vc0), 1);
      end
      if (k == 799) chk("dflt 799 hblnk", int'(hb2), 0);
      if (k == 800) begin
        chk("dflt 800 hblnk", int'(hb2), 1);
        chk("dflt 800 de", int'(de2), 0);
      end
      if (k == 839) chk("dflt 839 hsync", int'(hs2), 0);
      if (k == 840) chk("dflt 840 hsync", int'(hs2), 1);
      if (k == 967) chk("dflt 967 hsync", int'(hs2), 1);
      if (k == 968) chk("dflt 968 hsync", int'(hs2), 0);
    end
    chk("small frame line_starts", nls, 17);
    chk("small frame frame_starts", nfs, 1);
    chk("dflt hcount at 1055", int'(hc2), 1055);
    en = 1'b0;
    repeat (2) begin
      tick();
      chk("en=0 hcount hold", int'(hc2), 1055);
      chk("en=0 vcount hold", int'(vc2), 0);
      chk("en=0 line_start", int'(ls2), 0);
    end
    en = 1'b1;
    tick();
    chk("resume wrap hcount", int'(hc2), 0);
    chk("resume wrap vcount", int'(vc2), 1);
    chk("resume line_start", int'(ls2), 1);
    chk("resume frame_start", int'(fs2), 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart hcount", int'(hc0), 0);
    chk("restart vcount", int'(vc0), 0);
    chk("restart frame_start", int'(fs0), 1);
    chk("restart line_start", int'(ls0), 1);
    chk("restart de", int'(de0), 1);
    chk("restart dflt hcount", int'(hc2), 0);
    tick();
    chk("post restart hcount", int'(hc0), 1);
    chk("post restart frame_start", int'(fs0), 0);
    // Walk instance 0 to (22,13): inside both sync pulses and both blanking regions.
    repeat (424) tick();
    chk("sync region hcount", int'(hc0), 22);
    chk("sync region vcount", int'(vc0), 13);
    chk("sync region hsync", int'(hs0), 1);
    chk("sync region vsync", int'(vs0), 1);
    chk("sync region vblnk", int'(vb0), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst hcount", int'(hc0), 0);
    chk("async rst vcount", int'(vc0), 0);
    chk("async rst hsync", int'(hs0), 0);
    chk("async rst vsync", int'(vs0), 0);
    chk("async rst vblnk", int'(vb0), 0);
    chk("async rst de", int'(de0), 1);
    chk("async rst inv hsync", int'(hs1), 1);
    tick();
    rst = 1'b0;
    repeat (6000) begin
      tick();
      if (rst) rst = 1'b0;
      else rst = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    restart = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 88, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 4, vertical sync width in lines.
REQ-008 Parameter V_BP, default 23, vertical back porch in lines.
REQ-009 Parameter HSYNC_POL, default 1, active level of hsync.
REQ-010 Parameter VSYNC_POL, default 1, active level of vsync.
REQ-011 Parameter CNT_W, default 11, width of hcount and vcount.
REQ-012 Ports: clk, input, 1, pixel clock; rst, input, 1, reset; one clock, reset asynchronous and active-high.
REQ-013 en, input, 1, pixel advance enable; counters step only when en=1.
REQ-014 restart, input, 1, synchronous frame restart request.
REQ-015 hcount, output, CNT_W, current pixel column.
REQ-016 vcount, output, CNT_W, current line.
REQ-017 hblnk, vblnk, output, 1 each, horizontal/vertical blanking.
REQ-018 hsync, vsync, output, 1 each, sync at parameterised polarity.
REQ-019 de, output, 1, data enable = !hblnk && !vblnk.
REQ-020 line_start, frame_start, output, 1 each, single-cycle markers.

Function
REQ-021 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; HS_START = H_ACTIVE+H_FP; HS_STOP = HS_START+H_SYNC; same for V; H_TOTAL-1 and V_TOTAL-1 SHALL fit in CNT_W (elaboration-time assertion).
REQ-022 All outputs SHALL be registered, computed from next-state counts, so every flag is aligned with the hcount/vcount it describes.
REQ-023 en=1, hcount<H_TOTAL-1: hcount+1, vcount holds.
REQ-024 en=1, hcount=H_TOTAL-1: hcount to 0; vcount+1, or 0 when vcount=V_TOTAL-1.
REQ-025 en=0: counts, blank, sync, de hold; line_start and frame_start SHALL be 0.
REQ-026 hblnk=1 iff hcount in [H_ACTIVE, H_TOTAL-1]; vblnk=1 iff vcount in [V_ACTIVE, V_TOTAL-1].
REQ-027 hsync=HSYNC_POL iff hcount in [HS_START, HS_STOP-1], else !HSYNC_POL; vsync likewise with vcount and VSYNC_POL.
REQ-028 line_start=1 for one cycle when an en=1 step produces hcount=0; frame_start=1 for one cycle when such a step produces hcount=0 and vcount=0.
REQ-029 restart=1 (any en) SHALL force next state hcount=0, vcount=0 with flags computed for (0,0), frame_start=1 and line_start=1; restart overrides en and normal stepping.
REQ-030 Zero-width porch parameters SHALL be legal; sync/blank ranges then abut without gap.

Reset
REQ-031 While rst=1, asynchronously: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, line_start=0, frame_start=0.
REQ-032 After rst release, first en=1 cycle SHALL step to hcount=1, vcount=0; no frame_start is generated for the post-reset (0,0).
REQ-033 rst asserted mid-frame SHALL immediately return all outputs to REQ-031 values irrespective of clk.

Verification
REQ-034 Defaults, rst then en=1 for 1056*628 cycles -> hcount wraps 1055->0; vcount wraps 627->0; exactly one frame_start, 628 line_starts.
REQ-035 Defaults, hcount 799->800 -> hblnk 0->1, de 0; hcount 840..967 -> hsync=1; hcount 968 -> hsync=0.
REQ-036 Defaults, vcount 601..604 -> vsync=1, vcount 600..627 -> vblnk=1; HSYNC_POL=VSYNC_POL=0 -> both sync outputs inverted, reset level 1.
REQ-037 en toggled 1,0,0,1 at hcount=1055 -> hcount/vcount held during en=0, line_start=0; wrap and line_start occur on next en=1 cycle only.
REQ-038 restart pulsed at (hcount=500, vcount=300) -> next cycle (0,0), frame_start=1, line_start=1, de=1; then normal stepping to (1,0).
REQ-039 rst asserted asynchronously at (hcount=900, vcount=602) between clock edges -> hsync/vsync/blank/counts reach REQ-031 values before next edge.
